// File: rtl/timer_regs_pkg.sv
// Shared encodings and helpers for the CHIP-8 delay/sound timer block.
package timer_regs_pkg;

  localparam int CLOCK_SPEED              = 100_000;
  localparam int TONE_HZ                  = 400;
  localparam int DEFAULT_TONE_HALF_PERIOD = CLOCK_SPEED / (2 * TONE_HZ);

  localparam logic SEL_DT = 1'b0;
  localparam logic SEL_ST = 1'b1;

  typedef enum logic [1:0] {
    HS_IDLE = 2'd0,
    HS_ACK  = 2'd1,
    HS_DROP = 2'd2
  } hs_state_t;

  // Timers stop at zero instead of wrapping to 255.
  function automatic logic [7:0] sat_dec(input logic [7:0] v);
    return (v == 8'd0) ? 8'd0 : v - 8'd1;
  endfunction

endpackage

// File: rtl/tone_gen.sv
// Buzzer square-wave generator: half-period counter plus beep toggle flop.
module tone_gen #(
  parameter int HALF_PERIOD = 125,
  parameter int CNT_W       = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic beep
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF_PERIOD - 1);

  logic [CNT_W-1:0] cnt;

  // clr silences immediately; en only gates counting so the phase starts at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      beep <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      beep <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      beep <= ~beep;
    end else begin
      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/timer_regs.sv
// CHIP-8 delay/sound timer registers with a valid/ack CPU port and 60 Hz decrement.
module timer_regs
  import timer_regs_pkg::*;
#(
  parameter int TONE_HALF_PERIOD = DEFAULT_TONE_HALF_PERIOD,
  parameter int TONE_CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_60hz,
  input  logic       req_valid,
  input  logic       req_we,
  input  logic       req_sel,
  input  logic [7:0] req_wdata,
  output logic       req_ack,
  output logic [7:0] rdata,
  output logic [7:0] dt,
  output logic [7:0] st,
  output logic       sound_on,
  output logic       beep
);

  hs_state_t state;
  logic      accept;
  logic      wr_dt;
  logic      wr_st;

  assign accept = (state == HS_IDLE) && req_valid;
  assign wr_dt  = accept && req_we && (req_sel == SEL_DT);
  assign wr_st  = accept && req_we && (req_sel == SEL_ST);

  // DROP holds until the CPU releases req_valid, so a long request acts once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= HS_IDLE;
      req_ack <= 1'b0;
      rdata   <= 8'd0;
    end else begin
      case (state)
        HS_IDLE: begin
          if (req_valid) begin
            state   <= HS_ACK;
            req_ack <= 1'b1;
            if (!req_we) rdata <= (req_sel == SEL_ST) ? st : dt;
          end
        end
        HS_ACK: begin
          state   <= HS_DROP;
          req_ack <= 1'b0;
        end
        HS_DROP: begin
          if (!req_valid) state <= HS_IDLE;
        end
        default: begin
          state   <= HS_IDLE;
          req_ack <= 1'b0;
        end
      endcase
    end
  end

  // A write wins over the tick for its own register only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dt       <= 8'd0;
      st       <= 8'd0;
      sound_on <= 1'b0;
    end else begin
      if (wr_dt)          dt <= req_wdata;
      else if (tick_60hz) dt <= sat_dec(dt);
      if (wr_st)          st <= req_wdata;
      else if (tick_60hz) st <= sat_dec(st);
      sound_on <= (st != 8'd0);
    end
  end

  tone_gen #(
    .HALF_PERIOD (TONE_HALF_PERIOD),
    .CNT_W       (TONE_CNT_W)
  ) u_tone (
    .clk  (clk),
    .rst  (rst),
    .en   (sound_on),
    .clr  (st == 8'd0),
    .beep (beep)
  );

endmodule

// File: tb/tb_timer_regs.sv
// Self-checking bench for timer_regs: vector table, directed corner cases, random run vs model.
module tb_timer_regs;

  localparam int HP = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_60hz;
  logic       req_valid;
  logic       req_we;
  logic       req_sel;
  logic [7:0] req_wdata;
  logic       req_ack;
  logic [7:0] rdata;
  logic [7:0] dt;
  logic [7:0] st;
  logic       sound_on;
  logic       beep;

  timer_regs #(
    .TONE_HALF_PERIOD (HP),
    .TONE_CNT_W       (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick_60hz (tick_60hz),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_sel   (req_sel),
    .req_wdata (req_wdata),
    .req_ack   (req_ack),
    .rdata     (rdata),
    .dt        (dt),
    .st        (st),
    .sound_on  (sound_on),
    .beep      (beep)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Behavioural reference state
  logic [7:0] m_dt, m_st, m_rdata;
  bit         m_ack, m_wait, m_son;
  int         m_age;

  typedef struct {
    bit         we;
    bit         sel;
    logic [7:0] wdata;
    bit         tk;
    logic [7:0] e_dt;
    logic [7:0] e_st;
    logic [7:0] e_rdata;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_dt = 0; m_st = 0; m_rdata = 0;
    m_ack = 0; m_wait = 0; m_son = 0; m_age = 0;
  endtask

  task automatic model_step();
    bit         acc;
    logic [7:0] n_dt, n_st, n_rdata;
    bit         n_son;
    acc     = req_valid && !m_ack && !m_wait;
    n_dt    = (tick_60hz && m_dt > 0) ? m_dt - 8'd1 : m_dt;
    n_st    = (tick_60hz && m_st > 0) ? m_st - 8'd1 : m_st;
    if (acc && req_we) begin
      if (req_sel) n_st = req_wdata;
      else         n_dt = req_wdata;
    end
    n_rdata = (acc && !req_we) ? (req_sel ? m_st : m_dt) : m_rdata;
    n_son   = (m_st != 0);
    m_age   = (n_son && m_son) ? m_age + 1 : 0;
    m_wait  = m_ack || (m_wait && req_valid);
    m_ack   = acc;
    m_dt    = n_dt;
    m_st    = n_st;
    m_rdata = n_rdata;
    m_son   = n_son;
  endtask

  task automatic compare_model();
    check("model_req_ack",  req_ack,  m_ack);
    check("model_rdata",    rdata,    m_rdata);
    check("model_dt",       dt,       m_dt);
    check("model_st",       st,       m_st);
    check("model_sound_on", sound_on, m_son);
    check("model_beep",     beep,     m_son ? ((m_age / HP) % 2) : 0);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    compare_model();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick_60hz = 0; req_valid = 0; req_we = 0; req_sel = 0; req_wdata = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic req_begin(input bit we, input bit sel, input logic [7:0] wd, input bit tk);
    req_valid = 1; req_we = we; req_sel = sel; req_wdata = wd; tick_60hz = tk;
    cycle();
    tick_60hz = 0;
  endtask

  task automatic req_end();
    req_valid = 0;
    cycle();
    cycle();
  endtask

  initial begin
    logic [7:0] tick_exp [4];
    int acks, first_ack, last_tog, hold;
    bit prev_beep, acked;

    tbl[0] = '{1, 0, 8'd3,   0, 8'd3,  8'd0,   8'd0};
    tbl[1] = '{0, 0, 8'd0,   1, 8'd2,  8'd0,   8'd3};
    tbl[2] = '{1, 1, 8'd5,   1, 8'd1,  8'd5,   8'd0};
    tbl[3] = '{1, 0, 8'd10,  1, 8'd10, 8'd4,   8'd0};
    tbl[4] = '{0, 1, 8'd0,   1, 8'd9,  8'd3,   8'd4};
    tbl[5] = '{1, 1, 8'd0,   1, 8'd8,  8'd0,   8'd0};
    tbl[6] = '{0, 0, 8'd0,   0, 8'd8,  8'd0,   8'd8};
    tbl[7] = '{1, 0, 8'd0,   1, 8'd0,  8'd0,   8'd0};
    tbl[8] = '{0, 0, 8'd0,   1, 8'd0,  8'd0,   8'd0};
    tbl[9] = '{1, 1, 8'd255, 0, 8'd0,  8'd255, 8'd0};

    // Reset state
    apply_reset();
    check("rst_req_ack",  req_ack,  0);
    check("rst_rdata",    rdata,    0);
    check("rst_dt",       dt,       0);
    check("rst_st",       st,       0);
    check("rst_sound_on", sound_on, 0);
    check("rst_beep",     beep,     0);

    // Vector table: one request per record, tick optionally in the accept cycle
    for (int i = 0; i < 10; i++) begin
      req_begin(tbl[i].we, tbl[i].sel, tbl[i].wdata, tbl[i].tk);
      check($sformatf("tbl%0d_ack", i), req_ack, 1);
      check($sformatf("tbl%0d_dt", i), dt, tbl[i].e_dt);
      check($sformatf("tbl%0d_st", i), st, tbl[i].e_st);
      if (!tbl[i].we) check($sformatf("tbl%0d_rdata", i), rdata, tbl[i].e_rdata);
      req_end();
    end

    // DT = 3 then four ticks, saturating at zero
    apply_reset();
    req_begin(1, 0, 8'd3, 0);
    check("dt_load", dt, 3);
    req_end();
    tick_exp[0] = 2; tick_exp[1] = 1; tick_exp[2] = 0; tick_exp[3] = 0;
    for (int i = 0; i < 4; i++) begin
      tick_60hz = 1;
      cycle();
      tick_60hz = 0;
      check($sformatf("dt_tick%0d", i), dt, tick_exp[i]);
      cycle();
    end
    req_begin(0, 0, 8'd0, 0);
    check("dt_read_zero", rdata, 0);
    req_end();

    // ST = 2: sound_on latency, beep period, silence after two ticks
    apply_reset();
    req_begin(1, 1, 8'd2, 0);
    check("st_load", st, 2);
    check("son_not_yet", sound_on, 0);
    req_valid = 0;
    cycle();
    check("son_after_write", sound_on, 1);
    cycle();
    last_tog  = -1;
    prev_beep = beep;
    for (int i = 0; i < 14; i++) begin
      cycle();
      if (beep !== prev_beep) begin
        if (last_tog >= 0) check("beep_interval", cyc - last_tog, HP);
        last_tog = cyc;
      end
      prev_beep = beep;
    end
    check("beep_toggled", (last_tog >= 0), 1);
    tick_60hz = 1; cycle(); tick_60hz = 0; cycle();
    tick_60hz = 1; cycle(); tick_60hz = 0;
    check("st_zero", st, 0);
    cycle();
    check("son_off", sound_on, 0);
    check("beep_off", beep, 0);

    // Write DT with a coincident tick; ST still decrements
    apply_reset();
    req_begin(1, 0, 8'd10, 0); req_end();
    req_begin(1, 1, 8'd5, 0);  req_end();
    req_begin(1, 0, 8'd7, 1);
    check("wr_tick_dt", dt, 7);
    check("wr_tick_st", st, 4);
    req_end();

    // Read DT with a coincident tick returns the pre-decrement value
    req_begin(1, 0, 8'd10, 0); req_end();
    req_begin(0, 0, 8'd0, 1);
    check("rd_tick_ack",   req_ack, 1);
    check("rd_tick_rdata", rdata,   10);
    check("rd_tick_dt",    dt,      9);
    req_end();

    // Write held for six cycles: one ack, one load
    apply_reset();
    acks = 0;
    req_valid = 1; req_we = 1; req_sel = 0; req_wdata = 8'd20;
    for (int i = 0; i < 6; i++) begin
      tick_60hz = (i == 2);
      cycle();
      if (req_ack) acks++;
    end
    tick_60hz = 0;
    req_valid = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (req_ack) acks++;
    end
    check("hold_ack_count", acks, 1);
    check("hold_dt", dt, 19);

    // Reset in the ACK cycle with the request still held
    apply_reset();
    req_begin(1, 1, 8'd5, 0); req_end();
    req_begin(0, 1, 8'd0, 0);
    check("pre_rst_rdata", rdata, 5);
    rst = 1'b1;
    #1;
    check("mid_rst_req_ack",  req_ack,  0);
    check("mid_rst_rdata",    rdata,    0);
    check("mid_rst_dt",       dt,       0);
    check("mid_rst_st",       st,       0);
    check("mid_rst_sound_on", sound_on, 0);
    check("mid_rst_beep",     beep,     0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    acks = 0;
    first_ack = -1;
    for (int i = 1; i <= 5; i++) begin
      cycle();
      if (req_ack) begin
        acks++;
        if (first_ack < 0) first_ack = i;
      end
    end
    check("post_rst_ack_count", acks, 1);
    check("post_rst_ack_cycle", first_ack, 1);
    req_end();

    // Randomized traffic against the reference model
    apply_reset();
    acked = 0;
    hold  = 0;
    for (int i = 0; i < 600; i++) begin
      tick_60hz = ($urandom_range(0, 5) == 0);
      if (!req_valid) begin
        if ($urandom_range(0, 2) == 0) begin
          req_valid = 1;
          req_we    = ($urandom_range(0, 1) != 0);
          req_sel   = ($urandom_range(0, 1) != 0);
          req_wdata = 8'($urandom_range(0, 12));
        end
      end else if (acked) begin
        if (hold == 0) begin
          req_valid = 0;
          acked     = 0;
        end else begin
          hold--;
        end
      end
      cycle();
      if (m_ack) begin
        acked = 1;
        hold  = $urandom_range(0, 3);
      end
    end
    tick_60hz = 0;
    req_valid = 0;
    cycle();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
